// File: rtl/agu_ntt_dual.sv
// Dual-direction (NTT/INTT) butterfly address generator: one issue per cycle, write-back delayed by PIPE_LAT.
// Optional INTT scaling pass is enabled with macro AGU_INTT_SCALE_EN.
module agu_ntt_dual #(
  parameter int N        = 256,
  parameter int LOGN     = $clog2(N),
  parameter int AW       = $clog2(N),
  parameter int PIPE_LAT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic          stall_i,
  output logic          busy_o,
  output logic          valid_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o,
  output logic [AW-1:0] zeta_addr_o,
  output logic [AW-1:0] stage_o,
  output logic          wren_o,
  output logic [AW-1:0] wr_addr_a_o,
  output logic [AW-1:0] wr_addr_b_o,
  output logic          done_o,
  output logic          scale_o
);

  localparam int            NT     = (PIPE_LAT > 1) ? PIPE_LAT - 2 : 0;
  localparam logic [AW-1:0] B_LAST = AW'(N / 2 - 1);
  localparam logic [AW-1:0] S_LAST = AW'(LOGN - 1);
`ifdef AGU_INTT_SCALE_EN
  localparam logic [AW-1:0] C_LAST = AW'(N - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
`ifdef AGU_INTT_SCALE_EN
    , SCALE
`endif
  } state_t;

  state_t        state_q;
  logic          mode_q;
  logic [AW-1:0] s_q;
  logic [AW-1:0] b_q;
  logic          last_q;

  logic          wr_vld_p  [PIPE_LAT];
  logic          wr_last_p [PIPE_LAT];
  logic [AW-1:0] wr_a_p    [PIPE_LAT];
  logic [AW-1:0] wr_b_p    [PIPE_LAT];

  logic [AW-1:0] lg;
  logic [AW:0]   len;
  logic [AW:0]   g;
  logic [AW:0]   off;
  logic [AW-1:0] a_n;
  logic [AW-1:0] b_n;
  logic [AW-1:0] kn;
  logic [AW-1:0] ki;
  logic          last_nt;

  // Butterfly geometry for the current (stage, index); widths carry one extra bit so N/len never wraps.
  always_comb begin
    lg  = mode_q ? s_q : (S_LAST - s_q);
    len = (AW+1)'(1) << lg;
    g   = {1'b0, b_q} >> lg;
    off = {1'b0, b_q} & (len - (AW+1)'(1));
    a_n = AW'((g << (lg + AW'(1))) | off);
    b_n = a_n + len[AW-1:0];
    kn  = AW'(((AW+1)'(1) << (S_LAST - lg)) + g);
    ki  = AW'(((AW+1)'(1) << (AW'(LOGN) - lg)) - (AW+1)'(1) - g);
  end

  // DONE must coincide with the last write, so look one slot ahead of the delay-line tail.
  assign last_nt     = (PIPE_LAT > 1) ? wr_last_p[NT] : last_q;
  assign wren_o      = wr_vld_p[PIPE_LAT-1];
  assign wr_addr_a_o = wr_a_p[PIPE_LAT-1];
  assign wr_addr_b_o = wr_b_p[PIPE_LAT-1];
  assign done_o      = wr_last_p[PIPE_LAT-1];

`ifdef AGU_INTT_SCALE_EN
  logic scale_q;
  assign scale_o = scale_q;
`else
  assign scale_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      s_q         <= '0;
      b_q         <= '0;
      last_q      <= 1'b0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      addr_a_o    <= '0;
      addr_b_o    <= '0;
      zeta_addr_o <= '0;
      stage_o     <= '0;
`ifdef AGU_INTT_SCALE_EN
      scale_q     <= 1'b0;
`endif
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_vld_p[i]  <= 1'b0;
        wr_last_p[i] <= 1'b0;
        wr_a_p[i]    <= '0;
        wr_b_p[i]    <= '0;
      end
    end else begin
      // Write-back delay line: shifts every cycle, independent of stall.
      wr_vld_p[0]  <= valid_o;
      wr_last_p[0] <= last_q;
      wr_a_p[0]    <= addr_a_o;
      wr_b_p[0]    <= addr_b_o;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_vld_p[i]  <= wr_vld_p[i-1];
        wr_last_p[i] <= wr_last_p[i-1];
        wr_a_p[i]    <= wr_a_p[i-1];
        wr_b_p[i]    <= wr_b_p[i-1];
      end

      valid_o <= 1'b0;
      last_q  <= 1'b0;
`ifdef AGU_INTT_SCALE_EN
      scale_q <= 1'b0;
`endif

      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            s_q     <= '0;
            b_q     <= '0;
            busy_o  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!stall_i) begin
            valid_o     <= 1'b1;
            addr_a_o    <= a_n;
            addr_b_o    <= b_n;
            zeta_addr_o <= mode_q ? ki : kn;
            stage_o     <= s_q;
            if (b_q == B_LAST) begin
              b_q <= '0;
              if (s_q == S_LAST) begin
`ifdef AGU_INTT_SCALE_EN
                if (mode_q) begin
                  state_q <= SCALE;
                end else begin
                  last_q  <= 1'b1;
                  state_q <= DRAIN;
                end
`else
                last_q  <= 1'b1;
                state_q <= DRAIN;
`endif
              end else begin
                s_q <= s_q + AW'(1);
              end
            end else begin
              b_q <= b_q + AW'(1);
            end
          end
        end
`ifdef AGU_INTT_SCALE_EN
        SCALE: begin
          if (!stall_i) begin
            valid_o     <= 1'b1;
            scale_q     <= 1'b1;
            addr_a_o    <= b_q;
            addr_b_o    <= b_q;
            zeta_addr_o <= '0;
            if (b_q == C_LAST) begin
              last_q  <= 1'b1;
              state_q <= DRAIN;
            end else begin
              b_q <= b_q + AW'(1);
            end
          end
        end
`endif
        DRAIN: begin
          if (last_nt) state_q <= DONE;
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
